// File: rtl/conv1_mxmult_pkg.sv
// Shared sizing and state type for the conv1 layer1 multiplier-array sequencer.
package conv1_mxmult_pkg;

  localparam int unsigned MX_LANES      = 25;
  localparam int unsigned MX_LANE_IN_W  = 16;
  localparam int unsigned MX_LANE_OUT_W = 32;
  localparam int unsigned MX_RES_W      = MX_LANES * MX_LANE_OUT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RD,
    S_FEED,
    S_WAIT,
    S_NEXT,
    S_DRAIN
  } mx_state_e;

endpackage

// File: rtl/mxmult_res_fifo.sv
// Synchronous result FIFO with fall-through head and occupancy count.
// Head data reads as zero while empty.
module mxmult_res_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop, do_push;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is accepted when a pop frees the head slot in the same cycle.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= bump(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= bump(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign valid_o = (cnt_q != '0);
  assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/conv1_layer1_mxmult_sched.sv
// Row sequencer for the conv1 layer1 25-lane multiplier array; results queue in a tagged FIFO.
// Build option: MXMULT_SCHED_TIMEOUT_EN adds a watchdog on the WAIT state.
module conv1_layer1_mxmult_sched
  import conv1_mxmult_pkg::*;
#(
  parameter int unsigned N_ROWS      = 25,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned RES_W       = MX_RES_W,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_start,
  input  logic [ADDR_W:0]   job_rows,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] fea_addr,
  output logic              job_busy,
  output logic              job_done,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              fea_rd_en,
  output logic [ADDR_W-1:0] fea_rd_addr,
  output logic              arr_start,
  output logic              arr_data_v,
  input  logic              arr_res_v,
  input  logic [RES_W-1:0]  arr_res,
  output logic              res_v,
  output logic [RES_W-1:0]  res_data,
  output logic [ADDR_W-1:0] res_row,
  input  logic              res_ready,
  output logic              err
);

  localparam int unsigned ROWS_W = ADDR_W + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  mx_state_e               state_q, state_d;
  logic [ADDR_W-1:0]       row_q, row_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [ADDR_W-1:0]       fea_q, fea_d;
  logic [ROWS_W-1:0]       rows_q, rows_d;
  logic [ROWS_W-1:0]       rows_clamped;
  logic                    err_q, err_d;
  logic                    done_q, done_d;
  logic                    push;
  logic                    fifo_space;
  logic                    last_row;
  logic                    tmo_hit;
  logic [CNT_W-1:0]        fifo_cnt;
  logic [ADDR_W+RES_W-1:0] fifo_head;

  assign rows_clamped = (job_rows > ROWS_W'(N_ROWS)) ? ROWS_W'(N_ROWS) : job_rows;
  assign fifo_space   = (fifo_cnt < CNT_W'(FIFO_DEPTH));
  assign last_row     = ({1'b0, row_q} == (rows_q - ROWS_W'(1)));

`ifdef MXMULT_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_d   = (state_q == S_WAIT) ? tmo_q + TMO_W'(1) : '0;
  assign tmo_hit = (state_q == S_WAIT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      base_q  <= '0;
      fea_q   <= '0;
      rows_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      base_q  <= base_d;
      fea_q   <= fea_d;
      rows_q  <= rows_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    base_d  = base_q;
    fea_d   = fea_q;
    rows_d  = rows_q;
    err_d   = err_q | (arr_res_v && (state_q != S_WAIT));
    done_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (job_start) begin
          rows_d  = rows_clamped;
          base_d  = a_base;
          fea_d   = fea_addr;
          row_d   = '0;
          state_d = (rows_clamped == '0) ? S_DRAIN : S_ARM;
        end
      end
      S_ARM:  if (fifo_space) state_d = S_RD;
      S_RD:   state_d = S_FEED;
      S_FEED: state_d = S_WAIT;
      S_WAIT: begin
        if (arr_res_v) begin
          push    = 1'b1;
          state_d = S_NEXT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end
      end
      // Row advances only on the cycle we leave for RD, so a stall never skips a row.
      S_NEXT: begin
        if (last_row) begin
          state_d = S_DRAIN;
        end else if (fifo_space) begin
          row_d   = row_q + ADDR_W'(1);
          state_d = S_RD;
        end
      end
      S_DRAIN: begin
        if (fifo_cnt == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  mxmult_res_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ADDR_W + RES_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  ({row_q, arr_res}),
    .pop_i  (res_ready),
    .dout_o (fifo_head),
    .valid_o(res_v),
    .count_o(fifo_cnt)
  );

  assign job_busy    = (state_q != S_IDLE);
  assign job_done    = done_q;
  assign a_rd_en     = (state_q == S_RD);
  assign fea_rd_en   = (state_q == S_RD);
  assign a_rd_addr   = a_rd_en ? base_q + row_q : '0;
  assign fea_rd_addr = fea_rd_en ? fea_q : '0;
  assign arr_start   = (state_q == S_ARM);
  assign arr_data_v  = (state_q == S_FEED);
  assign res_row     = fifo_head[ADDR_W+RES_W-1 -: ADDR_W];
  assign res_data    = fifo_head[RES_W-1:0];
  assign err         = err_q;

endmodule

// File: tb/tb_conv1_layer1_mxmult_sched.sv
// Self-checking bench for conv1_layer1_mxmult_sched: job table, random jobs and corner sequences.
module tb_conv1_layer1_mxmult_sched;
  import conv1_mxmult_pkg::*;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned RES_W  = MX_RES_W;
  localparam int unsigned N_ROWS = 25;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned AMOD   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              job_start = 1'b0;
  logic [ADDR_W:0]   job_rows = '0;
  logic [ADDR_W-1:0] a_base = '0;
  logic [ADDR_W-1:0] fea_addr = '0;
  logic              job_busy, job_done, a_rd_en, fea_rd_en, arr_start, arr_data_v;
  logic [ADDR_W-1:0] a_rd_addr, fea_rd_addr, res_row;
  logic              arr_res_v = 1'b0;
  logic [RES_W-1:0]  arr_res = '0;
  logic              res_v, err;
  logic [RES_W-1:0]  res_data;
  logic              res_ready = 1'b0;

  always #5 clk = ~clk;

  conv1_layer1_mxmult_sched #(
    .N_ROWS(N_ROWS), .ADDR_W(ADDR_W), .RES_W(RES_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_rows(job_rows), .a_base(a_base),
    .fea_addr(fea_addr), .job_busy(job_busy), .job_done(job_done), .a_rd_en(a_rd_en),
    .a_rd_addr(a_rd_addr), .fea_rd_en(fea_rd_en), .fea_rd_addr(fea_rd_addr),
    .arr_start(arr_start), .arr_data_v(arr_data_v), .arr_res_v(arr_res_v), .arr_res(arr_res),
    .res_v(res_v), .res_data(res_data), .res_row(res_row), .res_ready(res_ready), .err(err)
  );

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic chk_data(input string nm, input logic [RES_W-1:0] act, input logic [RES_W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [RES_W-1:0] rnd_word();
    logic [RES_W-1:0] w;
    w = '0;
    for (int i = 0; i < MX_LANES; i++) w[i*MX_LANE_OUT_W +: MX_LANE_OUT_W] = $urandom;
    return w;
  endfunction

  // ---------------- observation (sampled on the falling edge) ----------------
  int unsigned       cyc = 0;
  int unsigned       n_start, n_dv, n_done, n_fea, feed_cnt = 0;
  int unsigned       start_cyc, done_cyc, last_pop_cyc, feed_cyc, err_cyc;
  bit                err_seen;
  logic [ADDR_W-1:0] rd_q[$];
  logic [ADDR_W-1:0] fea_q[$];
  logic [ADDR_W-1:0] prow_q[$];
  logic [RES_W-1:0]  pdat_q[$];

  always @(negedge clk) begin
    cyc++;
    if (job_start && !job_busy && rst) begin
      rd_q.delete(); fea_q.delete(); prow_q.delete(); pdat_q.delete();
      n_start = 0; n_dv = 0; n_done = 0; n_fea = 0; err_seen = 0;
      start_cyc = cyc; last_pop_cyc = 0; done_cyc = 0;
    end
    if (a_rd_en) rd_q.push_back(a_rd_addr);
    if (fea_rd_en) begin n_fea++; fea_q.push_back(fea_rd_addr); end
    if (arr_start) n_start++;
    if (arr_data_v) begin n_dv++; feed_cnt++; feed_cyc = cyc; end
    if (res_v && res_ready) begin
      prow_q.push_back(res_row); pdat_q.push_back(res_data); last_pop_cyc = cyc;
    end
    if (job_done) begin n_done++; done_cyc = cyc; end
    if (err && !err_seen) begin err_seen = 1; err_cyc = cyc; end
  end

  // ---------------- array model: answers each feed after lat WAIT cycles (0 = never) ----------------
  int unsigned      lat = 1;
  int unsigned      pend = 0;
  int unsigned      feed_taken = 0;
  int unsigned      spur_req = 0, spur_ack = 0;
  logic [RES_W-1:0] sent_q[$];

  initial begin
    forever begin
      @(posedge clk); #2;
      arr_res_v = 1'b0;
      if (job_start && !job_busy) sent_q.delete();
      if (!rst) begin
        pend = 0;
        feed_taken = feed_cnt;
      end else begin
        if (feed_taken != feed_cnt) begin feed_taken = feed_cnt; pend = lat; end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            arr_res_v = 1'b1; arr_res = rnd_word(); sent_q.push_back(arr_res);
          end
        end else if (spur_ack != spur_req) begin
          spur_ack = spur_req; arr_res_v = 1'b1; arr_res = rnd_word();
        end
      end
    end
  end

  // ---------------- job table ----------------
  typedef enum int {RDY_ON, RDY_HOLD, RDY_RAND} rdy_e;
  typedef struct {
    int unsigned rows;
    int unsigned base;
    int unsigned fea;
    int unsigned lat;
    rdy_e        rdy;
    bit          poke;
    int unsigned want_rows;
  } vec_t;

  vec_t tbl[8];

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 64'(job_busy), 0);
    chk({tag, "_done"}, 64'(job_done), 0);
    chk({tag, "_rd"}, 64'({a_rd_en, fea_rd_en, arr_start, arr_data_v}), 0);
    chk({tag, "_addr"}, 64'({a_rd_addr, fea_rd_addr}), 0);
    chk({tag, "_res_v"}, 64'(res_v), 0);
    chk_data({tag, "_res_data"}, res_data, '0);
    chk({tag, "_res_row"}, 64'(res_row), 0);
    chk({tag, "_err"}, 64'(err), 0);
  endtask

  task automatic run_job(input vec_t v);
    int unsigned k;
    bit          got;
    int unsigned want_stall;
    lat = v.lat;
    @(posedge clk); #1;
    job_rows  = v.rows[ADDR_W:0];
    a_base    = v.base[ADDR_W-1:0];
    fea_addr  = v.fea[ADDR_W-1:0];
    job_start = 1'b1;
    res_ready = (v.rdy == RDY_ON);
    k = 0; got = 0;
    while (!got && k < 3000) begin
      @(posedge clk); #1; k++;
      job_start = v.poke && (k == 3);
      if (job_start) begin job_rows = 2; a_base = a_base + 5'd16; end
      case (v.rdy)
        RDY_HOLD: res_ready = (k > 40);
        RDY_RAND: res_ready = 1'($urandom_range(0, 1));
        default:  res_ready = 1'b1;
      endcase
      @(negedge clk); #1;
      if (k == 1) chk("busy_after_start", 64'(job_busy), 1);
      if (v.rdy == RDY_HOLD && k == 40) begin
        want_stall = (v.want_rows < DEPTH) ? v.want_rows : DEPTH;
        chk("stall_reads", 64'(rd_q.size()), 64'(want_stall));
        chk("stall_pops", 64'(prow_q.size()), 0);
        chk("stall_res_v", 64'(res_v), 64'(v.want_rows > 0));
      end
      got = (n_done != 0);
    end
    chk("job_finish", 64'(got), 1);
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("n_done", 64'(n_done), 1);
    chk("n_arr_start", 64'(n_start), 64'(v.want_rows > 0));
    chk("n_data_v", 64'(n_dv), 64'(v.want_rows));
    chk("n_a_rd", 64'(rd_q.size()), 64'(v.want_rows));
    chk("n_fea_rd", 64'(n_fea), 64'(v.want_rows));
    for (int i = 0; i < rd_q.size(); i++) begin
      chk("a_rd_addr", 64'(rd_q[i]), 64'((v.base + i) % AMOD));
      chk("fea_rd_addr", 64'(fea_q[i]), 64'(v.fea));
    end
    chk("n_pop", 64'(prow_q.size()), 64'(v.want_rows));
    for (int i = 0; i < prow_q.size(); i++) begin
      chk("res_row", 64'(prow_q[i]), 64'(i));
      if (i < sent_q.size()) chk_data("res_data", pdat_q[i], sent_q[i]);
    end
    if (v.want_rows == 0) chk("zero_row_done_lat", 64'(done_cyc - start_cyc), 2);
    else chk("done_after_last_pop", 64'(done_cyc > last_pop_cyc), 1);
    chk("busy_end", 64'(job_busy), 0);
    chk("err_clean", 64'(err), 0);
    chk("res_v_end", 64'(res_v), 0);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{3,  4,  7,  3, RDY_ON,   1'b0, 3};
    tbl[1] = '{5,  10, 2,  1, RDY_HOLD, 1'b0, 5};
    tbl[2] = '{0,  1,  1,  1, RDY_ON,   1'b0, 0};
    tbl[3] = '{31, 30, 9,  2, RDY_ON,   1'b0, 25};
    tbl[4] = '{4,  8,  3,  2, RDY_ON,   1'b1, 4};
    tbl[5] = '{1,  31, 0,  5, RDY_RAND, 1'b0, 1};
    tbl[6] = '{25, 17, 12, 1, RDY_RAND, 1'b0, 25};
    tbl[7] = '{26, 0,  31, 4, RDY_ON,   1'b0, 25};

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    for (int t = 0; t < 8; t++) run_job(tbl[t]);

    for (int t = 0; t < 8; t++) begin
      v.rows = $urandom_range(0, 31);
      v.base = $urandom_range(0, AMOD - 1);
      v.fea  = $urandom_range(0, AMOD - 1);
      v.lat  = $urandom_range(1, 4);
      v.rdy  = ($urandom_range(0, 1) != 0) ? RDY_ON : RDY_RAND;
      v.poke = 1'b0;
      v.want_rows = (v.rows > N_ROWS) ? N_ROWS : v.rows;
      run_job(v);
    end

    // spurious array result while idle
    @(posedge clk); #1;
    spur_req++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("spurious_err", 64'(err), 1);
    chk("spurious_res_v", 64'(res_v), 0);
    chk("spurious_busy", 64'(job_busy), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_cleared_by_reset", 64'(err), 0);
    @(posedge clk); #1; rst = 1'b1;

    // reset in the middle of a job with results buffered
    lat = 2;
    @(posedge clk); #1;
    job_rows = 6; a_base = 3; fea_addr = 5; job_start = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1; job_start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("midjob_res_v_before_reset", 64'(res_v), 1);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet("midjob_reset");
    @(posedge clk); #1; rst = 1'b1; res_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midjob_no_done", 64'(n_done), 0);
    chk("midjob_idle", 64'(job_busy), 0);
    chk("midjob_err", 64'(err), 0);

`ifdef MXMULT_SCHED_TIMEOUT_EN
    begin
      int unsigned k;
      lat = 0;
      @(posedge clk); #1;
      job_rows = 3; a_base = 0; fea_addr = 0; job_start = 1'b1; res_ready = 1'b1;
      @(posedge clk); #1; job_start = 1'b0;
      k = 0;
      while (n_done == 0 && k < 200) begin
        @(posedge clk); k++;
      end
      @(negedge clk);
      chk("tmo_done", 64'(n_done), 1);
      chk("tmo_err", 64'(err), 1);
      chk("tmo_err_cycle", 64'(err_cyc - feed_cyc), 17);
      chk("tmo_feeds", 64'(n_dv), 1);
      chk("tmo_busy", 64'(job_busy), 0);
      chk("tmo_pops", 64'(prow_q.size()), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
